// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard, forwarding and flush controller for the pipelined MIPS core.
//   A shadow pipeline records the destination register of every instruction
//   in the DEPTH stages after ID (index 0 = EX, 1 = MEM, 2 = WB at default
//   depth). From it the block derives the ID stall, the IF/ID and ID/EX
//   flushes and the registered forward selects for the instruction in EX.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   id_valid            a valid instruction sits in ID
//   id_rs, id_rt        ID source registers; id_use_rs/id_use_rt qualify them
//   id_rd, id_wr        ID destination (already RegDst-muxed) and RegWr
//   id_load             ID instruction is a load
//   ex_redirect         taken branch/jump resolved in EX
//   freeze              whole-pipe hold (memory busy)
//   stall               hold PC and IF/ID (combinational)
//   flush_if_id         zero IF/ID (combinational)
//   flush_id_ex         bubble into ID/EX (combinational)
//   issue               ID instruction advances to EX this cycle (combinational)
//   ex_fwd_rs/rt        forward selects for the instruction in EX:
//                       0 = register file, k+1 = shadow entry k
//   stall_cnt           saturating count of stall cycles
//
// Flow control: the ID instruction moves to EX on a rising edge exactly when
// issue=1. issue drops for a load-use stall (instruction held in ID), for a
// redirect (instruction discarded) and for freeze (everything held). A
// redirect seen while frozen is ignored; EX keeps presenting it until freeze
// drops. FWD_W must satisfy 2**FWD_W > DEPTH so every select fits.

module pipe_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int FWD_W      = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             ex_redirect,
  input  logic             freeze,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             issue,
  output logic [FWD_W-1:0] ex_fwd_rs,
  output logic [FWD_W-1:0] ex_fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             load;
  } shadow_t;

  shadow_t          sh_q [DEPTH];

  logic [FWD_W-1:0] sel_rs;
  logic [FWD_W-1:0] sel_rt;
  logic             luh_rs;
  logic             luh_rt;
  logic             luh;

  // Scan oldest to youngest so the youngest matching writer overwrites any
  // older one. A matching load that is still too young to forward raises
  // the load-use hazard for that operand.
  always_comb begin
    sel_rs = '0;
    sel_rt = '0;
    luh_rs = 1'b0;
    luh_rt = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (id_use_rs && (id_rs != '0) && sh_q[k].v && sh_q[k].wr &&
          (sh_q[k].rd == id_rs)) begin
        sel_rs = FWD_W'(k + 1);
        luh_rs = sh_q[k].load && (k < LOAD_READY);
      end
      if (id_use_rt && (id_rt != '0) && sh_q[k].v && sh_q[k].wr &&
          (sh_q[k].rd == id_rt)) begin
        sel_rt = FWD_W'(k + 1);
        luh_rt = sh_q[k].load && (k < LOAD_READY);
      end
    end
  end

  assign luh = luh_rs | luh_rt;

  // A redirect outranks the load-use stall: the stalled instruction is on
  // the wrong path and is flushed instead. freeze masks everything.
  always_comb begin
    stall       = id_valid & luh & ~ex_redirect & ~freeze;
    flush_if_id = ex_redirect & ~freeze;
    flush_id_ex = (ex_redirect | stall) & ~freeze;
    issue       = id_valid & ~stall & ~ex_redirect & ~freeze;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        sh_q[k] <= '0;
      end
      ex_fwd_rs <= '0;
      ex_fwd_rt <= '0;
      stall_cnt <= '0;
    end else if (!freeze) begin
      for (int k = 1; k < DEPTH; k++) begin
        sh_q[k] <= sh_q[k-1];
      end
      // A stalled or flushed slot enters the shadow pipe as an invalid bubble.
      sh_q[0]   <= issue ? {1'b1, id_rd, id_wr, id_load} : '0;
      ex_fwd_rs <= issue ? sel_rs : '0;
      ex_fwd_rt <= issue ? sel_rt : '0;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. A list-based model of the in-flight
//   instructions predicts every output; a compare process checks the DUT
//   against it on each falling edge, and literal expectations at key points
//   pin the model. A second instance with a 4-bit stall counter shares all
//   inputs so counter saturation can be observed.

module tb_pipe_hazard_ctrl;

  localparam int REG_W      = 5;
  localparam int DEPTH      = 3;
  localparam int LOAD_READY = 1;
  localparam int FWD_W      = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             id_valid, id_use_rs, id_use_rt, id_wr, id_load;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             ex_redirect, freeze;
  logic             stall, flush_if_id, flush_id_ex, issue;
  logic [FWD_W-1:0] ex_fwd_rs, ex_fwd_rt;
  logic [31:0]      stall_cnt;

  logic             s4_stall, s4_flush_if_id, s4_flush_id_ex, s4_issue;
  logic [FWD_W-1:0] s4_fwd_rs, s4_fwd_rt;
  logic [3:0]       s4_cnt;

  pipe_hazard_ctrl #(.REG_W(REG_W), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY),
                     .FWD_W(FWD_W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .ex_redirect(ex_redirect), .freeze(freeze),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .issue(issue), .ex_fwd_rs(ex_fwd_rs), .ex_fwd_rt(ex_fwd_rt),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.REG_W(REG_W), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY),
                     .FWD_W(FWD_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .ex_redirect(ex_redirect), .freeze(freeze),
    .stall(s4_stall), .flush_if_id(s4_flush_if_id), .flush_id_ex(s4_flush_id_ex),
    .issue(s4_issue), .ex_fwd_rs(s4_fwd_rs), .ex_fwd_rt(s4_fwd_rt),
    .stall_cnt(s4_cnt)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pipe[0] is the instruction now in EX, pipe[DEPTH-1] the oldest tracked.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } ent_t;

  ent_t pipe [DEPTH];
  int   m_fwd_rs, m_fwd_rt;
  int   m_cnt;
  logic [63:0] exp_q[$];

  // Distance to the youngest in-flight writer of r, or -1 if none.
  function automatic int youngest(input logic [REG_W-1:0] r);
    for (int k = 0; k < DEPTH; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].rd == r) return k;
    return -1;
  endfunction

  task automatic model_eval(output bit st, output bit fif, output bit fex,
                            output bit iss, output int srs, output int srt);
    int  krs, krt;
    bit  luh;
    krs = (id_use_rs && id_rs != 0) ? youngest(id_rs) : -1;
    krt = (id_use_rt && id_rt != 0) ? youngest(id_rt) : -1;
    luh = (krs >= 0 && pipe[krs].ld && krs < LOAD_READY) ||
          (krt >= 0 && pipe[krt].ld && krt < LOAD_READY);
    st  = id_valid && luh && !ex_redirect && !freeze;
    fif = ex_redirect && !freeze;
    fex = (ex_redirect || st) && !freeze;
    iss = id_valid && !st && !ex_redirect && !freeze;
    srs = krs + 1;
    srt = krt + 1;
  endtask

  always @(posedge clk or negedge rst) begin
    bit st, fif, fex, iss;
    int srs, srt;
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] = '0;
      m_fwd_rs = 0;
      m_fwd_rt = 0;
      m_cnt    = 0;
    end else if (!freeze) begin
      model_eval(st, fif, fex, iss, srs, srt);
      for (int k = DEPTH - 1; k >= 1; k--) pipe[k] = pipe[k-1];
      pipe[0]  = iss ? {1'b1, id_rd, id_wr, id_load} : '0;
      m_fwd_rs = iss ? srs : 0;
      m_fwd_rt = iss ? srt : 0;
      if (st) m_cnt++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit st, fif, fex, iss;
    int srs, srt;
    if (rst && check_en) begin
      model_eval(st, fif, fex, iss, srs, srt);
      exp_q.push_back(64'(m_cnt > 15 ? 15 : m_cnt));
      chk("cmp_stall", stall, st);
      chk("cmp_flush_if_id", flush_if_id, fif);
      chk("cmp_flush_id_ex", flush_id_ex, fex);
      chk("cmp_issue", issue, iss);
      chk("cmp_fwd_rs", ex_fwd_rs, m_fwd_rs);
      chk("cmp_fwd_rt", ex_fwd_rt, m_fwd_rt);
      chk("cmp_stall_cnt", stall_cnt, m_cnt);
      chk("cmp_stall_cnt4", s4_cnt, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic instr(input bit v, input logic [REG_W-1:0] rs, input bit urs,
                       input logic [REG_W-1:0] rt, input bit urt,
                       input logic [REG_W-1:0] rd, input bit wr, input bit ld);
    id_valid  = v;
    id_rs     = rs;
    id_use_rs = urs;
    id_rt     = rt;
    id_use_rt = urt;
    id_rd     = rd;
    id_wr     = wr;
    id_load   = ld;
    @(negedge clk);
    #1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      instr(0, 0, 0, 0, 0, 0, 0, 0);
      next();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_rd = 0; id_wr = 0; id_load = 0; ex_redirect = 0; freeze = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    chk("reset_stall", stall, 0);
    chk("reset_flush_if_id", flush_if_id, 0);
    chk("reset_flush_id_ex", flush_id_ex, 0);
    chk("reset_fwd_rs", ex_fwd_rs, 0);
    chk("reset_fwd_rt", ex_fwd_rt, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    rst = 1'b1;
    next();
    check_en = 1'b1;

    // 1: ALU back-to-back, then with one unrelated instruction between
    instr(1, 0, 0, 0, 0, 3, 1, 0); chk("t1_add_issue", issue, 1); next();
    instr(1, 3, 1, 0, 0, 9, 1, 0); chk("t1_sub_stall", stall, 0); next();
    instr(0, 0, 0, 0, 0, 0, 0, 0); chk("t1_fwd_ex_mem", ex_fwd_rs, 1); next();
    nops(3);
    instr(1, 0, 0, 0, 0, 3, 1, 0); next();
    instr(1, 0, 0, 0, 0, 7, 1, 0); next();
    instr(1, 3, 1, 0, 0, 9, 1, 0); chk("t1_gap_stall", stall, 0); next();
    instr(0, 0, 0, 0, 0, 0, 0, 0); chk("t1_fwd_mem_wb", ex_fwd_rs, 2); next();

    // 2: load-use costs exactly one stall cycle
    nops(3);
    instr(1, 0, 0, 0, 0, 4, 1, 1); next();
    instr(1, 0, 0, 4, 1, 12, 1, 0);
    chk("t2_stall", stall, 1);
    chk("t2_flush_id_ex", flush_id_ex, 1);
    chk("t2_issue_held", issue, 0);
    chk("t2_cnt_before", stall_cnt, 0);
    next();
    instr(1, 0, 0, 4, 1, 12, 1, 0);
    chk("t2_stall_released", stall, 0);
    chk("t2_issue", issue, 1);
    chk("t2_cnt_after", stall_cnt, 1);
    next();
    instr(0, 0, 0, 0, 0, 0, 0, 0); chk("t2_fwd_rt", ex_fwd_rt, 2); next();

    // 3: $0 never forwards or stalls; double writer picks the younger
    nops(3);
    instr(1, 0, 0, 0, 0, 0, 1, 1); next();
    instr(1, 0, 1, 0, 1, 13, 1, 0); chk("t3_zero_stall", stall, 0); next();
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_zero_fwd_rs", ex_fwd_rs, 0);
    chk("t3_zero_fwd_rt", ex_fwd_rt, 0);
    next();
    instr(1, 0, 0, 0, 0, 5, 1, 1); next();
    instr(1, 0, 0, 0, 0, 5, 1, 0); next();
    instr(1, 5, 1, 0, 0, 16, 1, 0); chk("t3_dbl_stall", stall, 0); next();
    instr(0, 0, 0, 0, 0, 0, 0, 0); chk("t3_dbl_fwd", ex_fwd_rs, 1); next();

    // 4: redirect beats load-use
    nops(3);
    instr(1, 0, 0, 0, 0, 6, 1, 1); next();
    ex_redirect = 1;
    instr(1, 6, 1, 0, 0, 17, 1, 0);
    chk("t4_stall", stall, 0);
    chk("t4_flush_if_id", flush_if_id, 1);
    chk("t4_flush_id_ex", flush_id_ex, 1);
    chk("t4_issue", issue, 0);
    next();
    ex_redirect = 0;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_cnt_same", stall_cnt, 1);
    chk("t4_fwd_bubble", ex_fwd_rs, 0);
    next();

    // 5: freeze holds everything; forwarding result unchanged afterwards
    nops(3);
    instr(1, 0, 0, 0, 0, 8, 1, 0); next();
    instr(1, 8, 1, 0, 0, 9, 1, 0); next();
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      instr(1, 0, 0, 9, 1, 14, 1, 0);
      chk("t5_frz_stall", stall, 0);
      chk("t5_frz_issue", issue, 0);
      chk("t5_frz_fwd_rs", ex_fwd_rs, 1);
      chk("t5_frz_cnt", stall_cnt, 1);
      next();
    end
    freeze = 0;
    instr(1, 0, 0, 9, 1, 14, 1, 0); chk("t5_resume_issue", issue, 1); next();
    instr(0, 0, 0, 0, 0, 0, 0, 0); chk("t5_resume_fwd_rt", ex_fwd_rt, 1); next();

    // 6: asynchronous reset in the middle of a stall
    nops(3);
    instr(1, 0, 0, 0, 0, 10, 1, 1); next();
    instr(1, 10, 1, 0, 0, 15, 1, 0); chk("t6_pre_stall", stall, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_fwd_rs", ex_fwd_rs, 0);
    chk("t6_rst_fwd_rt", ex_fwd_rt, 0);
    chk("t6_rst_cnt", stall_cnt, 0);
    chk("t6_rst_stall", stall, 0);
    next();
    rst = 1'b1;
    instr(1, 10, 1, 0, 0, 15, 1, 0);
    chk("t6_post_stall", stall, 0);
    chk("t6_post_issue", issue, 1);
    next();

    // 6b: 17 load-use stalls; the 4-bit counter stops at 15
    nops(3);
    for (int i = 0; i < 17; i++) begin
      instr(1, 0, 0, 0, 0, 11, 1, 1); next();
      instr(1, 0, 0, 11, 1, 18, 1, 0); next();
      instr(1, 0, 0, 11, 1, 18, 1, 0); next();
    end
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_cnt32", stall_cnt, 17);
    chk("t6_cnt4_sat", s4_cnt, 15);
    next();

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
